// File: rtl/ralu_seq.sv
// ralu_seq: a register-based ALU with a small register file, a single-bit shifter
// and a sequencer. The sequencer runs three multi-cycle commands:
// shift-add multiply, shift left N times and shift right N times.
module ralu_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic             sel_a,
  input  logic [2:0]       v,
  input  logic [AW-1:0]    adr,
  input  logic             wr,
  input  logic             isl,
  input  logic             isr,
  output logic             osl,
  output logic             osr,
  input  logic             start,
  input  logic [1:0]       cmd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_MUL  = 2'b01;
  localparam logic [1:0] CMD_SHLN = 2'b10;
  localparam logic [1:0] CMD_SHRN = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rga_q, rga_d;
  logic [WIDTH-1:0] rgb_q, rgb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             osl_q, osl_d;
  logic             osr_q, osr_d;
  logic [WIDTH-1:0] rf_q [DEPTH];
  logic             rf_we;

  logic [WIDTH:0]   arith;
  logic [WIDTH-1:0] alu_r;
  logic             alu_cout;
  logic [WIDTH:0]   mul_sum;
  logic [CW-1:0]    cnt_req;

  // ALU: arithmetic is done one bit wider so the top bit is the carry-out
  always_comb begin
    arith    = '0;
    alu_r    = '0;
    alu_cout = 1'b0;
    case (op)
      3'b000: begin
        arith    = {1'b0, rga_q} + {1'b0, rgb_q} + {{WIDTH{1'b0}}, cin};
        alu_r    = arith[WIDTH-1:0];
        alu_cout = arith[WIDTH];
      end
      3'b001: begin
        arith    = {1'b0, rga_q} + {1'b0, ~rgb_q} + {{WIDTH{1'b0}}, cin};
        alu_r    = arith[WIDTH-1:0];
        alu_cout = arith[WIDTH];
      end
      3'b010:  alu_r = rga_q & rgb_q;
      3'b011:  alu_r = rga_q | rgb_q;
      3'b100:  alu_r = rga_q ^ rgb_q;
      3'b101:  alu_r = ~rga_q;
      3'b110:  alu_r = rga_q;
      default: alu_r = rgb_q;
    endcase
  end

  assign r    = alu_r;
  assign cout = alu_cout;
  assign zero = (alu_r == '0);
  assign acc  = acc_q;
  assign osl  = osl_q;
  assign osr  = osr_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_FIN);

  // Shift count requested by SHLN/SHRN, clamped so it never exceeds the word width
  always_comb begin
    cnt_req = data_in[CW-1:0];
    if (data_in[CW-1:0] > CW'(WIDTH)) begin
      cnt_req = CW'(WIDTH);
    end
  end

  // Next-state logic for the sequencer and all datapath registers
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    rga_d   = rga_q;
    rgb_d   = rgb_q;
    acc_d   = acc_q;
    osl_d   = osl_q;
    osr_d   = osr_q;
    rf_we   = 1'b0;
    // Partial-product add for one multiply step; the extra bit is shifted into acc
    mul_sum = {1'b0, acc_q} + (rgb_q[0] ? {1'b0, rga_q} : '0);

    case (state_q)
      S_IDLE: begin
        if (start && (cmd != CMD_NONE)) begin
          // A launched command takes the cycle; direct controls are dropped
          cmd_d = cmd;
          if (cmd == CMD_MUL) begin
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end else begin
            cnt_d   = cnt_req;
            state_d = (cnt_req == '0) ? S_FIN : S_RUN;
          end
        end else begin
          if (v[0]) begin
            rga_d = sel_a ? data_in : rf_q[adr];
          end
          case (v[2:1])
            2'b01: begin
              osl_d = rgb_q[WIDTH-1];
              rgb_d = {rgb_q[WIDTH-2:0], isl};
            end
            2'b10: begin
              osr_d = rgb_q[0];
              rgb_d = {isr, rgb_q[WIDTH-1:1]};
            end
            2'b11:   rgb_d = rf_q[adr];
            default: rgb_d = rgb_q;
          endcase
          rf_we = wr;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        case (cmd_q)
          CMD_MUL: begin
            acc_d = mul_sum[WIDTH:1];
            rgb_d = {mul_sum[0], rgb_q[WIDTH-1:1]};
          end
          CMD_SHLN: begin
            osl_d = rgb_q[WIDTH-1];
            rgb_d = {rgb_q[WIDTH-2:0], isl};
          end
          CMD_SHRN: begin
            osr_d = rgb_q[0];
            rgb_d = {isr, rgb_q[WIDTH-1:1]};
          end
          default: rgb_d = rgb_q;
        endcase
        if (cnt_q == CW'(1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_NONE;
      cnt_q   <= '0;
      rga_q   <= '0;
      rgb_q   <= '0;
      acc_q   <= '0;
      osl_q   <= 1'b0;
      osr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      rga_q   <= rga_d;
      rgb_q   <= rgb_d;
      acc_q   <= acc_d;
      osl_q   <= osl_d;
      osr_q   <= osr_d;
    end
  end

  // Register file: cleared on reset, so it is built from flops rather than RAM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[adr] <= alu_r;
    end
  end

endmodule

// File: doc/ralu_seq.md
RALU_SEQ -- requirements
Module: ralu_seq

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits (>=4).
REQ-002 Parameter DEPTH, default 8, register-file word count (power of two, >=2); AW = clog2(DEPTH), CW = clog2(WIDTH)+1.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  WIDTH  external operand; low CW bits double as shift count.
REQ-006 op  input  3  ALU function select.
REQ-007 cin  input  1  ALU carry-in.
REQ-008 sel_a  input  1  RgA load source: 1 = data_in, 0 = rf[adr].
REQ-009 v  input  3  direct control: v[0] load RgA; v[2:1] 01 shl RgB, 10 shr RgB, 11 load RgB from rf[adr], 00 hold.
REQ-010 adr  input  AW  register-file address.
REQ-011 wr  input  1  write r into rf[adr].
REQ-012 isl / isr  input  1 each  serial fill bit for left / right shift.
REQ-013 osl / osr  output  1 each  registered bit shifted out left / right.
REQ-014 start  input  1  launch sequenced command (single-cycle pulse).
REQ-015 cmd  input  2  00 none, 01 MUL, 10 SHLN, 11 SHRN.
REQ-016 busy  output  1  high while a command executes.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 r  output  WIDTH  combinational ALU result.
REQ-019 cout  output  1  ALU carry-out (bit WIDTH of the arithmetic result; 0 for logic ops).
REQ-020 zero  output  1  high when r == 0.
REQ-021 acc  output  WIDTH  accumulator (high half of MUL product).

Function
REQ-022 ALU on RgA (A), RgB (B): op 000 A+B+cin; 001 A+~B+cin; 010 A&B; 011 A|B; 100 A^B; 101 ~A; 110 A; 111 B; arithmetic carried in WIDTH+1 bits.
REQ-023 States IDLE, RUN, FIN; start/cmd, v and wr are acted on only in IDLE.
REQ-024 IDLE, start=1 and cmd!=00: command latched, v and wr ignored that cycle; start with cmd=00 ignored and v/wr act normally.
REQ-025 IDLE, no command: v[0] loads RgA; v[2:1] acts on RgB; wr writes r to rf[adr]; all effects at the same edge.
REQ-026 Single shl: osl <= RgB[WIDTH-1], RgB <= {RgB[WIDTH-2:0], isl}; single shr: osr <= RgB[0], RgB <= {isr, RgB[WIDTH-1:1]}.
REQ-027 MUL launch: acc <= 0, cnt <= WIDTH, state RUN.
REQ-028 MUL RUN step: sum = acc + (RgB[0] ? RgA : 0) in WIDTH+1 bits; {acc, RgB} <= {sum, RgB} >> 1; cnt decrements.
REQ-029 MUL result: after WIDTH steps {acc, RgB} = RgA*RgB unsigned (2*WIDTH bits); RgA unchanged.
REQ-030 SHLN/SHRN launch: cnt <= min(data_in[CW-1:0], WIDTH); cnt = 0 goes directly to FIN with RgB unchanged.
REQ-031 SHLN/SHRN RUN step: one shift per cycle per REQ-026 using current isl/isr; cnt decrements.
REQ-032 RUN -> FIN at the edge where cnt reaches 0; FIN -> IDLE unconditionally after one cycle.
REQ-033 busy = 1 exactly in RUN; done = 1 exactly in FIN; MUL start-to-done = WIDTH+1 edges, SHLN/SHRN = N+1 edges (N = clamped count, N = 0 gives 1).
REQ-034 start during RUN or FIN ignored, not queued; new command accepted from IDLE in the cycle after done.
REQ-035 r, cout and zero track RgA/RgB combinationally in every state, including during RUN.

Reset
REQ-036 reset low asynchronously clears RgA, RgB, acc, all rf words, cnt, osl, osr, busy and done to 0 and forces IDLE.
REQ-037 reset low mid-command aborts it with no done pulse; on release the block is in IDLE.

Verification (WIDTH=8, DEPTH=8)
REQ-038 RgA=0xF0, RgB=0x20, op=000, cin=0 -> r=0x10, cout=1, zero=0; op=001, cin=1, RgB=0xF0 -> r=0x00, zero=1.
REQ-039 RgA=13, RgB=11, start cmd=01 -> busy for 8 cycles, done on the 9th edge, acc=0x00, RgB=0x8F; RgA=RgB=0xFF -> acc=0xFE, RgB=0x01.
REQ-040 RgB=0x81, isl=1, start cmd=10, data_in=3 -> RgB=0x0F, osl=0, done 4 edges after start; data_in=0 -> done next edge, RgB unchanged.
REQ-041 start cmd=11 with data_in=15 -> count clamped to 8, isr=0 gives RgB=0x00, done 9 edges after start.
REQ-042 reset low 3 cycles into MUL -> busy=0, done never pulses, acc=RgA=RgB=0, rf[0..7]=0.
REQ-043 start=1, cmd=01 with v=001, wr=1 -> RgA and rf unchanged; start pulsed while busy -> ignored, single done pulse.
